dds_wave_gen: RTL and testbench

//  Parametrised DDS waveform generator: phase accumulator + on-the-fly wave shaper
//  (square w/ programmable duty, triangle, sawtooth), phase offset, power-of-2 attenuation.

---
 rtl/dds_pkg.sv | 21 ++
 rtl/dds_wave_shaper.sv | 34 +++
 rtl/dds_wave_gen.sv | 130 +++++++++++++
 tb/tb_dds_wave_gen.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared constants and types for the DDS waveform generator.
// Wave select codes, pipeline depth and per-sample mode fields.
package dds_pkg;

  localparam int SEL_W   = 2;
  localparam int ATTEN_W = 3;

  localparam logic [SEL_W-1:0] SEL_OFF    = 2'd0;
  localparam logic [SEL_W-1:0] SEL_SQUARE = 2'd1;
  localparam logic [SEL_W-1:0] SEL_TRI    = 2'd2;
  localparam logic [SEL_W-1:0] SEL_SAW    = 2'd3;

  localparam int DDS_LATENCY = 3;

  // Width-independent part of the configuration; freq and duty depend on module parameters.
  typedef struct packed {
    logic [SEL_W-1:0]   sel;
    logic [ATTEN_W-1:0] atten;
  } mode_t;

endpackage

// File: rtl/dds_wave_shaper.sv
// Combinational wave shaper: maps a phase address to an unsigned sample
// according to the selected waveform (off, square, triangle, sawtooth).
module dds_wave_shaper
  import dds_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 10
) (
  input  logic [SEL_W-1:0] i_sel,
  input  logic [AW-1:0]    i_duty,
  input  logic [AW-1:0]    i_addr,
  output logic [DW-1:0]    o_sample
);

  logic [DW-1:0] w_saw;
  logic [DW-1:0] w_ramp;
  logic [DW-1:0] w_tri;

  assign w_saw  = DW'(i_addr) << (DW - AW);
  assign w_ramp = DW'(i_addr[AW-2:0]) << (DW - AW + 1);
  // Falling half mirrors the rising ramp: all-ones minus x is simply ~x.
  assign w_tri  = i_addr[AW-1] ? ~w_ramp : w_ramp;

  always_comb begin
    o_sample = '0;
    case (i_sel)
      SEL_SQUARE: o_sample = (i_addr < i_duty) ? {DW{1'b1}} : {DW{1'b0}};
      SEL_TRI:    o_sample = w_tri;
      SEL_SAW:    o_sample = w_saw;
      default:    o_sample = '0;
    endcase
  end

endmodule

// File: rtl/dds_wave_gen.sv
// DDS waveform generator: phase accumulator with shadowed configuration and a
// three-stage pipeline in which each sample carries its own mode along.
module dds_wave_gen
  import dds_pkg::*;
#(
  parameter int PW = 24,
  parameter int AW = 8,
  parameter int DW = 10
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic [SEL_W-1:0]   i_sel,
  input  logic [PW-1:0]      i_freq,
  input  logic [AW-1:0]      i_phase_ofs,
  input  logic [AW-1:0]      i_duty,
  input  logic [ATTEN_W-1:0] i_atten,
  output logic               o_dout_en,
  output logic [DW-1:0]      o_dout,
  output logic               o_wrap
);

  if (DW < AW) begin : g_bad_dw
    $error("dds_wave_gen: DW must be >= AW");
  end
  if (AW > PW) begin : g_bad_aw
    $error("dds_wave_gen: AW must be <= PW");
  end
  if (AW < 2) begin : g_small_aw
    $error("dds_wave_gen: AW must be >= 2");
  end

  mode_t         r_mode_s;
  logic [PW-1:0] r_freq_s;
  logic [AW-1:0] r_duty_s;

  logic [PW-1:0] r_acc;
  logic          r_cy;
  logic [PW:0]   w_sum;
  logic          w_carry;

  logic          r_v1;
  logic          r_w1;
  logic [AW-1:0] r_a1;
  mode_t         r_mode1;
  logic [AW-1:0] r_duty1;

  logic          r_v2;
  logic          r_w2;
  logic [DW-1:0] r_s2;
  logic [ATTEN_W-1:0] r_atten2;

  logic          r_dout_en;
  logic [DW-1:0] r_dout;
  logic          r_wrap;

  logic [DW-1:0] w_shape;

  assign w_sum   = {1'b0, r_acc} + {1'b0, r_freq_s};
  assign w_carry = w_sum[PW];

  dds_wave_shaper #(
    .AW(AW),
    .DW(DW)
  ) u_shaper (
    .i_sel    (r_mode1.sel),
    .i_duty   (r_duty1),
    .i_addr   (r_a1),
    .o_sample (w_shape)
  );

  // Config only moves at a period boundary or while idle, so a period never mixes settings.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mode_s <= '0;
      r_freq_s <= '0;
      r_duty_s <= '0;
    end else if (!i_en || w_carry) begin
      r_mode_s <= '{sel: i_sel, atten: i_atten};
      r_freq_s <= i_freq;
      r_duty_s <= i_duty;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc <= '0;
      r_cy  <= 1'b0;
    end else begin
      r_acc <= i_en ? w_sum[PW-1:0] : '0;
      r_cy  <= i_en & w_carry;
    end
  end

  // The wrap flag rides beside the first sample taken after a rollover.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v1      <= 1'b0;
      r_w1      <= 1'b0;
      r_a1      <= '0;
      r_mode1   <= '0;
      r_duty1   <= '0;
      r_v2      <= 1'b0;
      r_w2      <= 1'b0;
      r_s2      <= '0;
      r_atten2  <= '0;
      r_dout_en <= 1'b0;
      r_dout    <= '0;
      r_wrap    <= 1'b0;
    end else begin
      r_v1      <= i_en;
      r_w1      <= i_en & r_cy;
      r_a1      <= r_acc[PW-1 -: AW] + i_phase_ofs;
      r_mode1   <= r_mode_s;
      r_duty1   <= r_duty_s;
      r_v2      <= r_v1;
      r_w2      <= r_w1;
      r_s2      <= w_shape;
      r_atten2  <= r_mode1.atten;
      r_dout_en <= r_v2;
      r_dout    <= r_v2 ? (r_s2 >> r_atten2) : '0;
      r_wrap    <= r_v2 & r_w2;
    end
  end

  assign o_dout_en = r_dout_en;
  assign o_dout    = r_dout;
  assign o_wrap    = r_wrap;

endmodule

// File: tb/tb_dds_wave_gen.sv
// Self-checking bench for dds_wave_gen (PW=AW=8, DW=10) against a
// sample-level reference model built from the waveform definitions.
module tb_dds_wave_gen;

  localparam int PW = 8;
  localparam int AW = 8;
  localparam int DW = 10;

  typedef struct packed {
    logic          v;
    logic [DW-1:0] d;
    logic          w;
  } sample_t;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          en    = 1'b0;
  logic [1:0]    sel   = 2'd0;
  logic [PW-1:0] freq  = '0;
  logic [AW-1:0] ofs   = '0;
  logic [AW-1:0] duty  = '0;
  logic [2:0]    atten = 3'd0;
  logic          dout_en;
  logic [DW-1:0] dout;
  logic          wrap;

  int checks = 0;
  int errors = 0;

  // Reference model state: phase, carry history, shadow config, output delay line.
  sample_t pipeQ[$];
  sample_t expS;
  int      phase     = 0;
  logic    carryPrev = 1'b0;
  logic [1:0] shSel   = 2'd0;
  int         shFreq  = 0;
  int         shDuty  = 0;
  int         shAtten = 0;

  int vals[0:599];
  logic wraps[0:599];
  int nVal;

  dds_wave_gen #(.PW(PW), .AW(AW), .DW(DW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_sel       (sel),
    .i_freq      (freq),
    .i_phase_ofs (ofs),
    .i_duty      (duty),
    .i_atten     (atten),
    .o_dout_en   (dout_en),
    .o_dout      (dout),
    .o_wrap      (wrap)
  );

  always #5 clk = ~clk;

  function automatic int shape(input logic [1:0] s, input int a, input int d);
    case (s)
      2'd1:    return (a < d) ? 1023 : 0;
      2'd2:    return (a < 128) ? a * 8 : 1023 - (a - 128) * 8;
      2'd3:    return a * 4;
      default: return 0;
    endcase
  endfunction

  task automatic loadShadow();
    shSel   = sel;
    shFreq  = int'(freq);
    shDuty  = int'(duty);
    shAtten = int'(atten);
  endtask

  // Advance one clock edge, update the model, and leave expS holding what the outputs should show.
  task automatic tick();
    sample_t e;
    int a;
    logic nc;
    @(posedge clk);
    if (rst) begin
      pipeQ = {sample_t'(0), sample_t'(0)};
      phase = 0;
      carryPrev = 1'b0;
      shSel = 2'd0; shFreq = 0; shDuty = 0; shAtten = 0;
      expS = '0;
    end else begin
      if (en) begin
        a = (phase + int'(ofs)) % 256;
        e.v = 1'b1;
        e.d = DW'(shape(shSel, a, shDuty) >> shAtten);
        e.w = carryPrev;
        nc = (phase + shFreq) >= 256;
        phase = (phase + shFreq) % 256;
        if (nc) loadShadow();
        carryPrev = nc;
      end else begin
        e = '0;
        phase = 0;
        carryPrev = 1'b0;
        loadShadow();
      end
      pipeQ.push_back(e);
      expS = pipeQ.pop_front();
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0;
    tick(); tick();
    rst = 1'b0; sel = 2'd3; freq = 8'd1; ofs = '0; duty = '0; atten = 3'd0;
    tick(); tick();
    en = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if ({dout_en, dout, wrap} !== expS) begin
        errors++;
        $display("[TB] FAIL reset_prerun c=%0d got %0b/%0d/%0b want %0b/%0d/%0b",
                 c, dout_en, dout, wrap, expS.v, expS.d, expS.w);
      end
    end
    rst = 1'b1;
    tick();
    checks++;
    if (dout_en !== 1'b0 || dout !== '0 || wrap !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got %0b/%0d/%0b want 0/0/0", dout_en, dout, wrap);
    end
    rst = 1'b0; en = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (dout_en !== 1'b0 || dout !== '0 || wrap !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_idle c=%0d got %0b/%0d/%0b want 0/0/0", c, dout_en, dout, wrap);
      end
    end
  endtask

  task automatic test_saw();
    int firstValid;
    en = 1'b0; sel = 2'd3; freq = 8'd1; ofs = '0; atten = 3'd0;
    repeat (3) tick();
    en = 1'b1; firstValid = -1; nVal = 0;
    for (int c = 0; c < 270; c++) begin
      tick();
      checks++;
      if ({dout_en, dout, wrap} !== expS) begin
        errors++;
        $display("[TB] FAIL saw_stream c=%0d got %0b/%0d/%0b want %0b/%0d/%0b",
                 c, dout_en, dout, wrap, expS.v, expS.d, expS.w);
      end
      if (dout_en === 1'b1) begin
        if (firstValid < 0) firstValid = c + 1;
        vals[nVal] = int'(dout); wraps[nVal] = wrap; nVal++;
      end
    end
    checks++;
    if (firstValid !== 3) begin
      errors++;
      $display("[TB] FAIL saw_latency got %0d edges want 3", firstValid);
    end
    checks++;
    if (vals[0] != 0 || vals[1] != 4 || vals[255] != 1020 || vals[256] != 0) begin
      errors++;
      $display("[TB] FAIL saw_values got %0d,%0d,%0d,%0d want 0,4,1020,0",
               vals[0], vals[1], vals[255], vals[256]);
    end
    checks++;
    if (wraps[0] !== 1'b0 || wraps[255] !== 1'b0 || wraps[256] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL saw_wrap got %0b,%0b,%0b want 0,0,1", wraps[0], wraps[255], wraps[256]);
    end
  endtask

  task automatic test_triangle();
    int maxLate;
    en = 1'b0; sel = 2'd2; freq = 8'd2; ofs = '0; atten = 3'd0;
    repeat (3) tick();
    en = 1'b1; nVal = 0;
    for (int c = 0; c < 140; c++) begin
      tick();
      checks++;
      if ({dout_en, dout, wrap} !== expS) begin
        errors++;
        $display("[TB] FAIL tri_stream c=%0d got %0b/%0d/%0b want %0b/%0d/%0b",
                 c, dout_en, dout, wrap, expS.v, expS.d, expS.w);
      end
      if (dout_en === 1'b1) begin
        vals[nVal] = int'(dout); wraps[nVal] = wrap; nVal++;
      end
    end
    checks++;
    if (vals[0] != 0 || vals[1] != 16 || vals[63] != 1008 || vals[64] != 1023 || vals[65] != 1007) begin
      errors++;
      $display("[TB] FAIL tri_values got %0d,%0d,%0d,%0d,%0d want 0,16,1008,1023,1007",
               vals[0], vals[1], vals[63], vals[64], vals[65]);
    end
    checks++;
    if (vals[128] != 0 || wraps[128] !== 1'b1 || wraps[127] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL tri_period got %0d wrap %0b/%0b want 0 wrap 0/1", vals[128], wraps[127], wraps[128]);
    end
    atten = 3'd2; maxLate = 0;
    for (int c = 0; c < 300; c++) begin
      tick();
      checks++;
      if ({dout_en, dout, wrap} !== expS) begin
        errors++;
        $display("[TB] FAIL tri_atten_stream c=%0d got %0b/%0d/%0b want %0b/%0d/%0b",
                 c, dout_en, dout, wrap, expS.v, expS.d, expS.w);
      end
      if (c >= 160 && int'(dout) > maxLate) maxLate = int'(dout);
    end
    checks++;
    if (maxLate != 255) begin
      errors++;
      $display("[TB] FAIL tri_atten_peak got %0d want 255", maxLate);
    end
  endtask

  task automatic test_square();
    int highs;
    int nonZero;
    en = 1'b0; sel = 2'd1; freq = 8'd1; duty = 8'd64; ofs = '0; atten = 3'd0;
    repeat (3) tick();
    en = 1'b1; nVal = 0;
    for (int c = 0; c < 258; c++) begin
      tick();
      checks++;
      if ({dout_en, dout, wrap} !== expS) begin
        errors++;
        $display("[TB] FAIL square_stream c=%0d got %0b/%0d/%0b want %0b/%0d/%0b",
                 c, dout_en, dout, wrap, expS.v, expS.d, expS.w);
      end
      if (dout_en === 1'b1) begin
        vals[nVal] = int'(dout); nVal++;
      end
    end
    highs = 0;
    for (int i = 0; i < 256; i++) if (vals[i] == 1023) highs++;
    checks++;
    if (highs != 64 || vals[63] != 1023 || vals[64] != 0) begin
      errors++;
      $display("[TB] FAIL square_duty got highs=%0d v63=%0d v64=%0d want 64/1023/0", highs, vals[63], vals[64]);
    end
    en = 1'b0; duty = 8'd0;
    repeat (4) tick();
    en = 1'b1; nonZero = 0;
    for (int c = 0; c < 262; c++) begin
      tick();
      checks++;
      if ({dout_en, dout, wrap} !== expS) begin
        errors++;
        $display("[TB] FAIL square_zero_stream c=%0d got %0b/%0d/%0b want %0b/%0d/%0b",
                 c, dout_en, dout, wrap, expS.v, expS.d, expS.w);
      end
      if (dout !== '0) nonZero++;
    end
    checks++;
    if (nonZero != 0) begin
      errors++;
      $display("[TB] FAIL square_duty0 got %0d nonzero samples want 0", nonZero);
    end
  endtask

  task automatic test_sel_change();
    en = 1'b0; sel = 2'd3; freq = 8'd1; ofs = '0; atten = 3'd0;
    duty = AW'($urandom_range(1, 255));
    repeat (3) tick();
    en = 1'b1; nVal = 0;
    for (int c = 0; c < 300; c++) begin
      if (c == 100) sel = 2'd1;
      tick();
      checks++;
      if ({dout_en, dout, wrap} !== expS) begin
        errors++;
        $display("[TB] FAIL selchg_stream c=%0d got %0b/%0d/%0b want %0b/%0d/%0b",
                 c, dout_en, dout, wrap, expS.v, expS.d, expS.w);
      end
      if (dout_en === 1'b1) begin
        vals[nVal] = int'(dout); wraps[nVal] = wrap; nVal++;
      end
    end
    checks++;
    if (vals[150] != 600 || vals[255] != 1020 || vals[256] != 1023 || wraps[256] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL selchg_boundary got %0d,%0d,%0d wrap %0b want 600,1020,1023 wrap 1",
               vals[150], vals[255], vals[256], wraps[256]);
    end
  endtask

  task automatic test_en_restart();
    logic [2:0] drainEn;
    en = 1'b0; sel = 2'd3; freq = 8'd1; ofs = 8'd128; atten = 3'd0;
    repeat (3) tick();
    en = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      checks++;
      if ({dout_en, dout, wrap} !== expS) begin
        errors++;
        $display("[TB] FAIL restart_run c=%0d got %0b/%0d/%0b want %0b/%0d/%0b",
                 c, dout_en, dout, wrap, expS.v, expS.d, expS.w);
      end
    end
    en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      drainEn[c] = dout_en;
      checks++;
      if ({dout_en, dout, wrap} !== expS) begin
        errors++;
        $display("[TB] FAIL restart_drain c=%0d got %0b/%0d/%0b want %0b/%0d/%0b",
                 c, dout_en, dout, wrap, expS.v, expS.d, expS.w);
      end
    end
    checks++;
    if (drainEn !== 3'b011 || dout !== '0) begin
      errors++;
      $display("[TB] FAIL restart_fall got en_hist=%b dout=%0d want 011 and 0", drainEn, dout);
    end
    tick(); tick();
    en = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (dout_en !== 1'b1 || dout !== 10'd512 || wrap !== 1'b0) begin
      errors++;
      $display("[TB] FAIL restart_first got %0b/%0d/%0b want 1/512/0", dout_en, dout, wrap);
    end
  endtask

  task automatic test_random();
    int len;
    for (int seg = 0; seg < 12; seg++) begin
      sel   = 2'($urandom_range(0, 3));
      freq  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      duty  = 8'($urandom_range(0, 255));
      atten = 3'($urandom_range(0, 7));
      ofs   = 8'($urandom_range(0, 255));
      en    = ($urandom_range(0, 4) != 0);
      rst   = ($urandom_range(0, 9) == 0);
      len   = $urandom_range(60, 200);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 7) == 0) ofs = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 29) == 0) sel = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 29) == 0) atten = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 39) == 0) en = ~en;
        tick();
        rst = 1'b0;
        checks++;
        if ({dout_en, dout, wrap} !== expS) begin
          errors++;
          $display("[TB] FAIL random_stream seg=%0d c=%0d got %0b/%0d/%0b want %0b/%0d/%0b",
                   seg, c, dout_en, dout, wrap, expS.v, expS.d, expS.w);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_saw();
    test_triangle();
    test_square();
    test_sel_change();
    test_en_restart();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
